// File: rtl/keypad_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : keypad_event_fifo
// Description : Window-based debouncer for a scanned 4x4 keypad that queues
//               each confirmed press code in a 4-deep first-word-fall-through
//               FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_event_fifo #(
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rows,
    input  logic [3:0] key_code,
    input  logic       rd_en,
    output logic [3:0] rd_data,
    output logic       empty,
    output logic       full,
    output logic [2:0] count,
    output logic       key_down,
    output logic       press_pulse,
    output logic       overflow
);

    localparam logic [3:0] c_SCAN_TARGET = 4'(DEBOUNCE_SCANS);
    localparam logic [0:0] c_ST_IDLE     = 1'b0;
    localparam logic [0:0] c_ST_PRESSED  = 1'b1;

    logic [1:0] r_wc;
    logic       r_hit_acc;
    logic [0:0] r_state;
    logic [3:0] r_cnt;
    logic       r_press_pulse;
    logic       r_overflow;
    logic [1:0] r_wr_ptr;
    logic [1:0] r_rd_ptr;
    logic [2:0] r_count;
    logic [3:0] r_mem [0:3];

    logic       w_row_hit;
    logic       w_win_end;
    logic       w_win_hit;
    logic [3:0] w_cnt_inc;
    logic       w_cnt_done;
    logic       w_push;
    logic       w_pop;
    logic       w_wr;
    logic       w_empty;
    logic       w_full;

    assign w_row_hit  = (rows != 4'b1111);
    assign w_win_end  = (r_wc == 2'd3);
    assign w_win_hit  = r_hit_acc | w_row_hit;
    assign w_cnt_inc  = r_cnt + 4'd1;
    assign w_cnt_done = (w_cnt_inc == c_SCAN_TARGET);

    // Only the IDLE->PRESSED confirmation produces an event.
    assign w_push = w_win_end && (r_state == c_ST_IDLE) && w_win_hit && w_cnt_done;

    assign w_empty = (r_count == 3'd0);
    assign w_full  = (r_count == 3'd4);
    assign w_pop   = rd_en && !w_empty;
    // When full, a simultaneous pop frees the slot the write pointer targets.
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wc      <= 2'd0;
            r_hit_acc <= 1'b0;
        end else begin
            r_wc      <= r_wc + 2'd1;
            r_hit_acc <= w_win_end ? 1'b0 : w_win_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_cnt         <= 4'd0;
            r_press_pulse <= 1'b0;
        end else begin
            r_press_pulse <= w_push;
            if (w_win_end) begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (!w_win_hit) begin
                            r_cnt <= 4'd0;
                        end else if (w_cnt_done) begin
                            r_cnt   <= 4'd0;
                            r_state <= c_ST_PRESSED;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        if (w_win_hit) begin
                            r_cnt <= 4'd0;
                        end else if (w_cnt_done) begin
                            r_cnt   <= 4'd0;
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            r_count    <= 3'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            r_count <= r_count + {2'b00, w_wr} - {2'b00, w_pop};
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage is left untouched by reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= key_code;
        end
    end

    assign rd_data     = r_mem[r_rd_ptr];
    assign empty       = w_empty;
    assign full        = w_full;
    assign count       = r_count;
    assign key_down    = (r_state == c_ST_PRESSED);
    assign press_pulse = r_press_pulse;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_keypad_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_event_fifo
// Description : Directed self-checking bench for keypad_event_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_event_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] rows = 4'hF;
    logic [3:0] key_code = 4'h0;
    logic       rd_en = 1'b0;
    logic [3:0] rd_data;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       key_down;
    logic       press_pulse;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int phase  = 0;

    keypad_event_fifo #(.DEBOUNCE_SCANS(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .rows       (rows),
        .key_code   (key_code),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .key_down   (key_down),
        .press_pulse(press_pulse),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are observed there too.
    task automatic step(input logic [3:0] r, input logic [3:0] kc, input logic rd);
        rows     = r;
        key_code = kc;
        rd_en    = rd;
        @(negedge clk);
        phase = (phase + 1) % 4;
    endtask

    // One scan window; a hit is a single active row on the wc==2 cycle.
    task automatic win(input bit hit, input logic [3:0] kc, input logic [3:0] rdmask);
        for (int p = 0; p < 4; p++) begin
            step((hit && p == 2) ? 4'b1110 : 4'b1111, kc, rdmask[p]);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        rows  = 4'hF;
        rd_en = 1'b0;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        phase = 0;
    endtask

    task automatic press_release(input logic [3:0] kc);
        repeat (3) win(1, kc, 4'b0000);
        repeat (3) win(0, kc, 4'b0000);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty actual=%b expected=1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full actual=%b expected=0", full); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count actual=%0d expected=0", count); end
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL reset_key_down actual=%b expected=0", key_down); end
        checks++; if (press_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse actual=%b expected=0", press_pulse); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow actual=%b expected=0", overflow); end
    endtask

    task automatic test_single_press();
        do_reset();
        win(1, 4'hA, 4'b0000);
        win(1, 4'hA, 4'b0000);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_early actual=%b expected=1", empty); end
        win(1, 4'hA, 4'b0000);
        checks++; if (press_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse actual=%b expected=1", press_pulse); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty actual=%b expected=0", empty); end
        checks++; if (rd_data !== 4'hA) begin errors++; $display("FAIL single_data actual=%h expected=a", rd_data); end
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL single_key_down actual=%b expected=1", key_down); end
        win(0, 4'hA, 4'b0000);
        checks++; if (press_pulse !== 1'b0) begin errors++; $display("FAIL single_pulse_low actual=%b expected=0", press_pulse); end
        win(0, 4'hA, 4'b0000);
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL single_hold actual=%b expected=1", key_down); end
        win(0, 4'hA, 4'b0000);
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL single_release actual=%b expected=0", key_down); end
    endtask

    task automatic test_bounce();
        do_reset();
        win(1, 4'h5, 4'b0000);
        win(0, 4'h5, 4'b0000);
        win(1, 4'h5, 4'b0000);
        win(1, 4'h5, 4'b0000);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL bounce_early actual=%0d expected=0", count); end
        win(1, 4'h5, 4'b0000);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL bounce_count actual=%0d expected=1", count); end
        checks++; if (rd_data !== 4'h5) begin errors++; $display("FAIL bounce_data actual=%h expected=5", rd_data); end
        repeat (2) win(1, 4'h5, 4'b0000);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL bounce_single actual=%0d expected=1", count); end
    endtask

    task automatic test_hold_release();
        do_reset();
        repeat (10) win(1, 4'hA, 4'b0000);
        repeat (10) win(1, 4'h7, 4'b0000);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL hold_no_repeat actual=%0d expected=1", count); end
        repeat (2) win(0, 4'h3, 4'b0000);
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL hold_still_down actual=%b expected=1", key_down); end
        win(0, 4'h3, 4'b0000);
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL hold_released actual=%b expected=0", key_down); end
        repeat (3) win(1, 4'h3, 4'b0000);
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL hold_count actual=%0d expected=2", count); end
        checks++; if (rd_data !== 4'hA) begin errors++; $display("FAIL hold_first actual=%h expected=a", rd_data); end
        step(4'hF, 4'h3, 1'b1);
        checks++; if (rd_data !== 4'h3) begin errors++; $display("FAIL hold_second actual=%h expected=3", rd_data); end
        step(4'hF, 4'h3, 1'b1);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL hold_drained actual=%b expected=1", empty); end
    endtask

    task automatic test_overflow();
        logic [3:0] exp_code;
        do_reset();
        for (int k = 1; k <= 4; k++) press_release(4'(k));
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full4 actual=%b expected=1", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_not_yet actual=%b expected=0", overflow); end
        press_release(4'h5);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count actual=%0d expected=4", count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag actual=%b expected=1", overflow); end
        for (int k = 1; k <= 4; k++) begin
            exp_code = 4'(k);
            checks++; if (rd_data !== exp_code) begin errors++; $display("FAIL ovf_read%0d actual=%h expected=%h", k, rd_data, exp_code); end
            step(4'hF, 4'h0, 1'b1);
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_drained actual=%b expected=1", empty); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky actual=%b expected=1", overflow); end
    endtask

    task automatic test_full_pop();
        logic [3:0] exp_q [4];
        exp_q = '{4'h2, 4'h3, 4'h4, 4'h9};
        do_reset();
        for (int k = 1; k <= 4; k++) press_release(4'(k));
        win(1, 4'h9, 4'b0000);
        win(1, 4'h9, 4'b0000);
        win(1, 4'h9, 4'b1000);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fpop_count actual=%0d expected=4", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpop_overflow actual=%b expected=0", overflow); end
        checks++; if (press_pulse !== 1'b1) begin errors++; $display("FAIL fpop_pulse actual=%b expected=1", press_pulse); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (rd_data !== exp_q[k]) begin errors++; $display("FAIL fpop_read%0d actual=%h expected=%h", k, rd_data, exp_q[k]); end
            step(4'hF, 4'h0, 1'b1);
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fpop_drained actual=%b expected=1", empty); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        press_release(4'hA);
        repeat (3) win(1, 4'hB, 4'b0000);
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL rmid_pre_count actual=%0d expected=2", count); end
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL rmid_pre_down actual=%b expected=1", key_down); end
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        phase = 0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmid_empty actual=%b expected=1", empty); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rmid_count actual=%0d expected=0", count); end
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL rmid_down actual=%b expected=0", key_down); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_overflow actual=%b expected=0", overflow); end
        step(4'hF, 4'h0, 1'b1);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rmid_rd_empty actual=%0d expected=0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmid_rd_flag actual=%b expected=1", empty); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_hold_release();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_event_fifo.md
KEYPAD_EVENT_FIFO -- requirements
Module: keypad_event_fifo

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as follows.
REQ-002 The block SHALL provide parameter DEBOUNCE_SCANS, default 3, legal range 2..15: the number of consecutive scan windows needed to confirm a press or a release.
REQ-003 The block SHALL have port clk, input, 1 bit: the system clock, the same clock that drives the column scanner.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port rows, input, 4 bits: the keypad row lines, active-low; the value 4'b1111 means no key in the currently driven column.
REQ-006 The block SHALL have port key_code, input, 4 bits: the registered key code from the 4x4 scanner.
REQ-007 The block SHALL have port rd_en, input, 1 bit: pops the oldest event when not empty.
REQ-008 The block SHALL have port rd_data, output, 4 bits: the oldest queued key code, valid while empty is 0.
REQ-009 The block SHALL have ports empty and full, outputs, 1 bit each: FIFO status.
REQ-010 The block SHALL have port count, output, 3 bits: the number of queued events, 0..4.
REQ-011 The block SHALL have port key_down, output, 1 bit: high while a debounced key is held.
REQ-012 The block SHALL have port press_pulse, output, 1 bit: a one-cycle strobe when a press is confirmed.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a confirmed press is dropped because the FIFO is full.

Function
REQ-014 Scan window:
- 2-bit counter wc increments every cycle and wraps 3->0.
- A window is the 4 cycles with wc = 0..3; the window ends on the cycle where wc==3.
REQ-015 Window hit:
- hit = OR over the 4 window cycles of (rows != 4'b1111), including the end cycle.
- The hit accumulator clears at the start of each new window.
REQ-016 Debounce FSM states:
- IDLE and PRESSED.
- A 4-bit counter cnt is evaluated only at window ends.
REQ-017 IDLE state:
- A hit window increments cnt; a non-hit window clears cnt.
- When cnt would reach DEBOUNCE_SCANS: go to PRESSED, clear cnt, and generate a push of key_code as sampled on that end cycle.
REQ-018 PRESSED state:
- A non-hit window increments cnt; a hit window clears cnt.
- When cnt would reach DEBOUNCE_SCANS: go to IDLE and clear cnt.
- No push occurs in this state.
REQ-019 key_down SHALL equal (state==PRESSED), registered.
REQ-020 press_pulse SHALL be high for exactly the one cycle following the confirming window end.
REQ-021 A change of key while in PRESSED (hit windows continue) SHALL NOT generate a new event; a new event requires a confirmed release first.
REQ-022 FIFO organisation:
- 4 entries x 4 bits, circular, with 2-bit read and write pointers.
- Pointers wrap 3->0.
- count is 3 bits.
REQ-023 rd_data SHALL show the entry at the read pointer (first-word-fall-through, no read latency); rd_data is don't-care when empty.
REQ-024 rd_en while empty SHALL be ignored: no pointer move and no error.
REQ-025 A push while not full SHALL write the entry at the write pointer and increment count; the data becomes visible on the next cycle.
REQ-026 A push while full and without rd_en SHALL be dropped, with count unchanged and overflow set.
REQ-027 A push and a pop in the same cycle SHALL be handled as follows:
- Both are performed and count is unchanged.
- This holds even when the FIFO is full, in which case no overflow occurs.
REQ-028 Status outputs:
- empty = (count==0).
- full = (count==4).
- Both are derived from the registered count.

Reset
REQ-029 On rst=1 at a clk edge, the block SHALL set:
- wc=0, hit accumulator=0, state=IDLE, cnt=0.
- Both pointers=0, count=0, empty=1, full=0.
- key_down=0, press_pulse=0, overflow=0.
REQ-030 Reset asserted mid-debounce or with events queued SHALL discard all state and queued events; the FIFO storage contents need not be cleared.
REQ-031 After reset is released, the first window SHALL start at wc=0 on the first cycle with rst=0.

Verification
REQ-032 Stimulus: DEBOUNCE_SCANS=3; rows=4'b1110 on every wc==2 cycle from reset release; key_code=4'hA. Required response: push at the end of window 3 (cycle 11); press_pulse=1 and empty=0 in cycle 12; rd_data=4'hA.
REQ-033 Stimulus: a bouncing press (hit, no-hit, hit, hit windows). Required response: no push until 3 consecutive hit windows; exactly one event is queued.
REQ-034 Stimulus: key held for 20 windows, then released for 3 windows, then pressed again with key_code=4'h3. Required response: exactly 2 events, 4'hA then 4'h3; key_down drops at the end of the 3rd no-hit window.
REQ-035 Stimulus: 5 confirmed presses with no reads. Required response: count=4, full=1, overflow=1; the first four codes are read out in order.
REQ-036 Stimulus: FIFO full with rd_en=1 in the push cycle. Required response: count stays 4, overflow stays 0, the oldest entry is popped, and the new code is last.
REQ-037 Stimulus: rst pulsed with 2 events queued and state PRESSED. Required response: the next cycle shows empty=1, count=0, key_down=0, overflow=0; rd_en while empty leaves count=0.
